ic_fetch: RTL and testbench

IC_FETCH -- requirements
Module: ic_fetch

---
 rtl/ic_fetch.sv | 87 ++++++++
 tb/tb_ic_fetch.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ic_fetch.sv
// ic_fetch: icache fetch requester with in-flight credits, stale-response discard after redirect, and a decode FIFO.
module ic_fetch #(
  parameter int LADDR_W = 50,
  parameter int DATA_W = 128,
  parameter int QDEPTH = 4,
  parameter logic [LADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [LADDR_W-1:0] redirect_pc,
  output logic               coretoic_valid,
  input  logic               coretoic_retry,
  output logic [LADDR_W-1:0] coretoic_pc,
  input  logic               ictocore_valid,
  output logic               ictocore_retry,
  input  logic [DATA_W-1:0]  ictocore_data,
  output logic               fetch_valid,
  input  logic               fetch_retry,
  output logic [LADDR_W-1:0] fetch_pc,
  output logic [DATA_W-1:0]  fetch_data
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  localparam logic [LADDR_W-1:0] ALIGN = ~LADDR_W'(15);
  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;
  function automatic ptr_t inc(input ptr_t p);
    return p == ptr_t'(QDEPTH - 1) ? '0 : p + ptr_t'(1);
  endfunction
  logic [LADDR_W-1:0] pc_q, pc_d;
  cnt_t inflight_q, inflight_d, stale_q, stale_d, cnt_q, cnt_d;
  ptr_t tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d, ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;
  logic [LADDR_W-1:0] tq_mem [QDEPTH];
  logic [LADDR_W-1:0] ff_pc_mem [QDEPTH];
  logic [DATA_W-1:0] ff_dat_mem [QDEPTH];
  logic acc, take, keep, pop;
  logic [CW:0] occ;
  // Redirect wins: it empties both queues, so same-cycle pushes and pops are simply dropped.
  always_comb begin
    occ = {1'b0, inflight_q} + {1'b0, cnt_q};
    coretoic_valid = !reset && occ < (CW+1)'(QDEPTH) && inflight_q < cnt_t'(QDEPTH);
    coretoic_pc = pc_q;
    ictocore_retry = !reset && stale_q == '0 && cnt_q == cnt_t'(QDEPTH);
    fetch_valid = !reset && cnt_q != '0;
    fetch_pc = ff_pc_mem[ff_rd_q];
    fetch_data = ff_dat_mem[ff_rd_q];
    acc = coretoic_valid && !coretoic_retry;
    take = ictocore_valid && !ictocore_retry;
    keep = take && stale_q == '0 && !redirect_valid;
    pop = fetch_valid && !fetch_retry && !redirect_valid;
    inflight_d = inflight_q + cnt_t'(acc) - cnt_t'(take);
    stale_d = redirect_valid ? inflight_d : (take && stale_q != '0) ? stale_q - cnt_t'(1) : stale_q;
    pc_d = redirect_valid ? (redirect_pc & ALIGN) : acc ? pc_q + LADDR_W'(16) : pc_q;
    tq_wr_d = redirect_valid ? '0 : acc ? inc(tq_wr_q) : tq_wr_q;
    tq_rd_d = redirect_valid ? '0 : keep ? inc(tq_rd_q) : tq_rd_q;
    ff_wr_d = redirect_valid ? '0 : keep ? inc(ff_wr_q) : ff_wr_q;
    ff_rd_d = redirect_valid ? '0 : pop ? inc(ff_rd_q) : ff_rd_q;
    cnt_d = redirect_valid ? '0 : cnt_q + cnt_t'(keep) - cnt_t'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC & ALIGN;
      inflight_q <= '0;
      stale_q <= '0;
      cnt_q <= '0;
      tq_wr_q <= '0;
      tq_rd_q <= '0;
      ff_wr_q <= '0;
      ff_rd_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      stale_q <= stale_d;
      cnt_q <= cnt_d;
      tq_wr_q <= tq_wr_d;
      tq_rd_q <= tq_rd_d;
      ff_wr_q <= ff_wr_d;
      ff_rd_q <= ff_rd_d;
    end
    if (acc) tq_mem[tq_wr_q] <= pc_q;
    if (keep) begin
      ff_pc_mem[ff_wr_q] <= tq_mem[tq_rd_q];
      ff_dat_mem[ff_wr_q] <= ictocore_data;
    end
  end
endmodule

// File: tb/tb_ic_fetch.sv
// tb_ic_fetch: randomized scoreboard bench for ic_fetch; the model tracks requests by redirect epoch.
module tb_ic_fetch;
  localparam int LADDR_W = 50;
  localparam int DATA_W = 128;
  localparam int QDEPTH = 4;
  localparam logic [LADDR_W-1:0] RESET_PC = '0;
  typedef struct {
    logic [LADDR_W-1:0] pc;
    logic [DATA_W-1:0] data;
    int ep;
  } blk_t;
  logic clk = 1'b0;
  logic reset, redirect_valid, coretoic_valid, coretoic_retry;
  logic ictocore_valid, ictocore_retry, fetch_valid, fetch_retry;
  logic [LADDR_W-1:0] redirect_pc, coretoic_pc, fetch_pc, model_pc;
  logic [DATA_W-1:0] ictocore_data, fetch_data;
  blk_t ic_q[$];
  blk_t exp_q[$];
  blk_t b;
  int epoch = 0, cur_fifo = 0, n_stale = 0, checks = 0, errors = 0;
  int p_cr = 0, p_rsp = 0, p_fr = 0, p_rd = 0;
  bit rsp_en = 1'b0;
  always #5 clk = ~clk;
  ic_fetch #(.LADDR_W(LADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .coretoic_valid(coretoic_valid), .coretoic_retry(coretoic_retry), .coretoic_pc(coretoic_pc),
    .ictocore_valid(ictocore_valid), .ictocore_retry(ictocore_retry), .ictocore_data(ictocore_data),
    .fetch_valid(fetch_valid), .fetch_retry(fetch_retry), .fetch_pc(fetch_pc), .fetch_data(fetch_data)
  );
  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: compares the decode head against the expected queue and pops on a real handshake.
  always @(negedge clk) begin
    cur_fifo = exp_q.size();
    if (!reset) begin
      chk("fetch_valid", DATA_W'(fetch_valid), DATA_W'(exp_q.size() != 0));
      if (fetch_valid && exp_q.size() != 0) begin
        chk("fetch_pc", DATA_W'(fetch_pc), DATA_W'(exp_q[0].pc));
        chk("fetch_data", fetch_data, exp_q[0].data);
        if (!fetch_retry && !redirect_valid) void'(exp_q.pop_front());
      end
    end
  end
  // Reference model: records what the coming edge does to requests, responses and redirects.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      chk("rst_coretoic_valid", DATA_W'(coretoic_valid), '0);
      chk("rst_fetch_valid", DATA_W'(fetch_valid), '0);
      chk("rst_ictocore_retry", DATA_W'(ictocore_retry), '0);
      ic_q.delete();
      exp_q.delete();
      model_pc = RESET_PC & ~LADDR_W'(15);
      epoch++;
    end else begin
      n_stale = 0;
      foreach (ic_q[i]) if (ic_q[i].ep != epoch) n_stale++;
      chk("credit", DATA_W'(coretoic_valid), DATA_W'(ic_q.size() + cur_fifo < QDEPTH && ic_q.size() < QDEPTH));
      chk("ictocore_retry", DATA_W'(ictocore_retry), DATA_W'(n_stale == 0 && cur_fifo == QDEPTH));
      if (ictocore_valid && !ictocore_retry && ic_q.size() != 0) begin
        b = ic_q.pop_front();
        if (!redirect_valid && b.ep == epoch) exp_q.push_back(b);
      end
      if (coretoic_valid && !coretoic_retry) begin
        chk("coretoic_pc", DATA_W'(coretoic_pc), DATA_W'(model_pc));
        b.pc = model_pc;
        b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.ep = epoch;
        ic_q.push_back(b);
        model_pc = model_pc + LADDR_W'(16);
      end
      if (redirect_valid) begin
        epoch++;
        model_pc = redirect_pc & ~LADDR_W'(15);
        exp_q.delete();
      end
    end
  end
  task automatic drive();
    coretoic_retry = $urandom_range(99) < p_cr;
    fetch_retry = $urandom_range(99) < p_fr;
    redirect_valid = $urandom_range(99) < p_rd;
    redirect_pc = $urandom_range(7) == 0 ? '1 : LADDR_W'({$urandom(), $urandom()});
    ictocore_valid = rsp_en && ic_q.size() != 0 && $urandom_range(99) < p_rsp;
    ictocore_data = ic_q.size() != 0 ? ic_q[0].data : '0;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    redirect_valid = 1'b0;
    ictocore_valid = 1'b0;
    coretoic_retry = 1'b0;
    fetch_retry = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    coretoic_retry = 1'b0;
    ictocore_valid = 1'b0;
    ictocore_data = '0;
    fetch_retry = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("seq_valid", DATA_W'(coretoic_valid), DATA_W'(i < 4));
      if (i < 4) chk("seq_pc", DATA_W'(coretoic_pc), DATA_W'(i * 16));
      @(posedge clk);
      #1;
      drive();
    end
    do_reset();
    @(posedge clk);
    #1;
    coretoic_retry = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("retry_hold_pc", DATA_W'(coretoic_pc), DATA_W'('h10));
      @(posedge clk);
      #1;
    end
    coretoic_retry = 1'b0;
    @(negedge clk);
    chk("retry_release_pc", DATA_W'(coretoic_pc), DATA_W'('h10));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("retry_advance_pc", DATA_W'(coretoic_pc), DATA_W'('h20));
    do_reset();
    rsp_en = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin p_cr = 30; p_rsp = 60; p_fr = 30; p_rd = 0; end
        1: begin p_cr = 10; p_rsp = 80; p_fr = 50; p_rd = 3; end
        2: begin p_cr = 50; p_rsp = 40; p_fr = 20; p_rd = 10; end
        default: begin p_cr = 0; p_rsp = 100; p_fr = 0; p_rd = 5; end
      endcase
      repeat (2000) begin
        @(posedge clk);
        #1;
        drive();
      end
    end
    p_cr = 0; p_rsp = 50; p_fr = 100; p_rd = 0;
    for (int k = 0; k < 200 && !(ic_q.size() >= 2 && exp_q.size() >= 1); k++) begin
      @(posedge clk);
      #1;
      drive();
    end
    chk("midop_setup_reached", DATA_W'(ic_q.size() >= 2 && exp_q.size() >= 1), DATA_W'(1));
    do_reset();
    @(negedge clk);
    chk("midop_fetch_valid", DATA_W'(fetch_valid), '0);
    chk("midop_coretoic_pc", DATA_W'(coretoic_pc), DATA_W'(RESET_PC & ~LADDR_W'(15)));
    chk("midop_coretoic_valid", DATA_W'(coretoic_valid), DATA_W'(1));
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
